usb_xact_engine: RTL and testbench
==================================

# usb_xact_engine

Parametrised host-side USB transaction engine sitting between the read/write front end and the packet encoder/decoder. It runs complete IN and OUT transactions (token, data, handshake) and supports a configurable payload width, retry limit and response timeout. It keeps a DATA0/DATA1 toggle bit for each endpoint, retries the whole transaction on NAK, corruption or timeout, and finishes immediately on STALL.

## Interface
- DATA_BYTES, 8: payload bytes per data packet.
- MAX_TRIES, 8: total attempts, including the first, before giving up; must be ≥1.
- TIMEOUT_CYCLES, 255: wait-state cycles without a decoder response before a timeout; must be ≥2.
- NUM_EP, 4: number of endpoints with a tracked toggle; valid endp values are 0..NUM_EP-1.
- clk  in  1  clock.
- rst_b  in  1  asynchronous, active-low reset.
- start  in  1  transaction request; sampled only in IDLE.
- is_in  in  1  1 = IN transaction, 0 = OUT transaction; sampled with start.
- addr  in  7  device address; sampled with start.
- endp  in  4  endpoint number; sampled with start.
- wdata  in  8*DATA_BYTES  OUT payload; sampled with start.
- toggle_clr  in  1  clears all toggle bits to DATA0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- status  out  2  result, valid while done is high: 0 OK, 1 NAK_LIMIT, 2 ERR_LIMIT, 3 STALL.
- rdata  out  8*DATA_BYTES  IN payload; held until the next successful IN.
- rdata_valid  out  1  one-cycle pulse when new IN data is delivered.
- enc_valid  out  1  packet offered to the encoder.
- enc_ready  in  1  encoder accepts the packet when enc_valid and enc_ready are both high.
- enc_pid  out  8  packet ID.
- enc_addr  out  7  token address.
- enc_endp  out  4  token endpoint.
- enc_data  out  8*DATA_BYTES  data payload.
- dec_valid  in  1  one-cycle pulse: decoded packet present.
- dec_pid  in  8  decoded packet ID.
- dec_data  in  8*DATA_BYTES  decoded payload.
- dec_corrupt  in  1  CRC or bit-stuff error; qualified by dec_valid.
- re  out  1  receive enable; high in WAIT_HS and WAIT_DATA.

## Operation
- PIDs: OUT E1, IN 69, DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E.
- States: IDLE, TOKEN, DATA_OUT, WAIT_HS, WAIT_DATA, SEND_ACK, DONE.
- IDLE:
  - On start, latch is_in, addr, endp and wdata.
  - Set tries to 1.
  - Go to TOKEN.
- TOKEN: drive enc_pid = IN or OUT, with enc_addr and enc_endp from the latched values. On the handshake, go to DATA_OUT if the transaction is OUT, or WAIT_DATA if it is IN.
- DATA_OUT: drive enc_pid = DATA0 or DATA1 according to toggle[endp], and enc_data = wdata. On the handshake, go to WAIT_HS.
- WAIT_HS (dec_valid events):
  - ACK: flip toggle[endp]; finish with OK.
  - STALL: finish with STALL.
  - NAK: fail with class NAK.
  - Corrupt or any other PID: fail with class ERR.
  - Timeout: fail with class ERR.
- WAIT_DATA (dec_valid events):
  - Clean DATA0 or DATA1 whose PID matches toggle[endp]: load rdata, pulse rdata_valid, flip the toggle, go to SEND_ACK.
  - Clean DATA0 or DATA1 whose PID does not match (a duplicate): go to SEND_ACK without delivering data and without flipping the toggle.
  - NAK: fail with class NAK.
  - STALL: finish with STALL.
  - Corrupt: fail with class ERR; no handshake is sent.
  - Timeout: fail with class ERR.
- SEND_ACK: drive enc_pid = ACK. On the handshake, finish with OK.
- Fail:
  - If tries < MAX_TRIES: increment tries and return to TOKEN.
  - Otherwise finish with status NAK_LIMIT or ERR_LIMIT, following the class of the last failure.
- Finish: go to DONE. DONE asserts done and status for one cycle, then returns to IDLE.
- toggle_clr: clears the toggle bits in any state. If it coincides with a toggle flip, the clear wins.
- endp ≥ NUM_EP: the transaction still runs; the toggle is read as 0 and is never written.

## Timing
- Reset values:
  - State: IDLE.
  - Toggles: 0.
  - tries: 0.
  - Timeout counter: 0.
  - Outputs: all 0, including rdata.
- Reset asserted mid-transaction aborts it immediately, with no done pulse.
- start seen in IDLE at cycle N: busy and enc_valid are high at N+1.
- start while busy is ignored.
- enc_valid and the enc_* fields stay stable until the handshake. enc_valid drops in the cycle after the handshake.
- enc_valid is low in every wait state and in DONE.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES).
  - Cleared on entry to WAIT_HS or WAIT_DATA.
  - Increments each cycle in those states.
  - Timeout fires in the wait cycle where the count equals TIMEOUT_CYCLES-1 and dec_valid is low.
  - If dec_valid coincides with the timeout cycle, dec_valid wins.
- dec_valid outside the wait states is ignored.
- Latency from response to done:
  - OUT: the ACK in WAIT_HS at cycle M gives done at M+1.
  - IN: done comes one cycle after the SEND_ACK handshake.
- rdata_valid coincides with the WAIT_DATA-to-SEND_ACK transition cycle.

## Test plan
- OUT to endpoint 1, encoder always ready, device ACKs 3 cycles after DATA:
  - Encoder sees E1 then C3, with enc_data equal to wdata.
  - done shows status 0.
  - toggle[1] becomes 1.
  - A second OUT to endpoint 1 sends 4B.
- IN to endpoint 0, device returns clean DATA0 with payload 0x0123456789ABCDEF:
  - rdata_valid pulses with that rdata.
  - Encoder sees D2.
  - done shows status 0.
- IN, first response DATA1 while toggle[0] is 0:
  - ACK is sent, rdata_valid stays 0, the toggle is unchanged, status is 0.
- OUT, device NAKs every attempt with MAX_TRIES=8:
  - Exactly 8 OUT tokens are sent.
  - done shows status 1.
  - The toggle is unchanged.
- IN with no device response and TIMEOUT_CYCLES=16:
  - Each attempt waits 16 cycles.
  - Corrupt data on attempt 3 counts as a retry and sends no handshake.
  - After the final attempt, status is 2.
- STALL on the first attempt: exactly one token is sent, then status is 3.
- toggle_clr pulsed in the same cycle as an ACK: the toggle stays 0.
- Reset mid-WAIT_HS: the block returns to IDLE with no done pulse.

Source files
------------

// File: rtl/usb_xact_engine.sv
// Host-side USB transaction engine: runs IN/OUT token-data-handshake sequences with
// per-endpoint DATA0/DATA1 toggles, bounded retries and a response timeout.
module usb_xact_engine #(
  parameter int DATA_BYTES     = 8,
  parameter int MAX_TRIES      = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int NUM_EP         = 4
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    start,
  input  logic                    is_in,
  input  logic [6:0]              addr,
  input  logic [3:0]              endp,
  input  logic [8*DATA_BYTES-1:0] wdata,
  input  logic                    toggle_clr,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              status,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    rdata_valid,
  output logic                    enc_valid,
  input  logic                    enc_ready,
  output logic [7:0]              enc_pid,
  output logic [6:0]              enc_addr,
  output logic [3:0]              enc_endp,
  output logic [8*DATA_BYTES-1:0] enc_data,
  input  logic                    dec_valid,
  input  logic [7:0]              dec_pid,
  input  logic [8*DATA_BYTES-1:0] dec_data,
  input  logic                    dec_corrupt,
  output logic                    re
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_TRIES + 1);

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // State code is {busy, enc_valid, re, index}, so those three outputs are plain
  // state-register bits and need no separate registers to stay in step.
  typedef enum logic [4:0] {
    IDLE      = 5'b000_00,
    TOKEN     = 5'b110_00,
    DATA_OUT  = 5'b110_01,
    SEND_ACK  = 5'b110_10,
    WAIT_HS   = 5'b101_00,
    WAIT_DATA = 5'b101_01,
    DONE      = 5'b100_00
  } state_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_NAK_LIMIT = 2'd1,
    ST_ERR_LIMIT = 2'd2,
    ST_STALL     = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_ACK,
    EV_STALL,
    EV_NAK,
    EV_ERR,
    EV_DATA,
    EV_DUP
  } event_t;

  state_t          state;
  status_t         status_q;
  event_t          evt;
  logic            in_q;
  logic [6:0]      addr_q;
  logic [3:0]      endp_q;
  logic [DW-1:0]   wdata_q;
  logic [NUM_EP-1:0] toggle;
  logic [NUM_EP-1:0] ep_mask;
  logic            cur_tog;
  logic [TW-1:0]   tcnt;
  logic [RW-1:0]   tries;

  assign busy      = state[4];
  assign enc_valid = state[3];
  assign re        = state[2];
  assign status    = status_q;
  assign enc_addr  = addr_q;
  assign enc_endp  = endp_q;
  assign enc_data  = wdata_q;

  // Out-of-range endpoints select no mask bit: their toggle reads 0 and never flips.
  always_comb begin
    ep_mask = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      ep_mask[i] = (endp_q == 4'(i));
    end
    cur_tog = |(toggle & ep_mask);
  end

  // Classify the decoder activity of the current wait cycle; dec_valid beats timeout.
  always_comb begin
    evt = EV_NONE;
    if (dec_valid) begin
      if (dec_corrupt)
        evt = EV_ERR;
      else if (dec_pid == PID_STALL)
        evt = EV_STALL;
      else if (dec_pid == PID_NAK)
        evt = EV_NAK;
      else if (state == WAIT_HS && dec_pid == PID_ACK)
        evt = EV_ACK;
      else if (state == WAIT_DATA && (dec_pid == PID_DATA0 || dec_pid == PID_DATA1))
        evt = ((dec_pid == PID_DATA1) == cur_tog) ? EV_DATA : EV_DUP;
      else
        evt = EV_ERR;
    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      evt = EV_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      status_q    <= ST_OK;
      done        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      enc_pid     <= '0;
      in_q        <= 1'b0;
      addr_q      <= '0;
      endp_q      <= '0;
      wdata_q     <= '0;
      toggle      <= '0;
      tcnt        <= '0;
      tries       <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            in_q    <= is_in;
            addr_q  <= addr;
            endp_q  <= endp;
            wdata_q <= wdata;
            tries   <= RW'(1);
            enc_pid <= is_in ? PID_IN : PID_OUT;
            state   <= TOKEN;
          end
        end

        TOKEN: begin
          if (enc_ready) begin
            if (in_q) begin
              tcnt  <= '0;
              state <= WAIT_DATA;
            end else begin
              enc_pid <= cur_tog ? PID_DATA1 : PID_DATA0;
              state   <= DATA_OUT;
            end
          end
        end

        DATA_OUT: begin
          if (enc_ready) begin
            tcnt  <= '0;
            state <= WAIT_HS;
          end
        end

        WAIT_HS, WAIT_DATA: begin
          tcnt <= tcnt + 1'b1;
          case (evt)
            EV_ACK: begin
              toggle   <= toggle ^ ep_mask;
              status_q <= ST_OK;
              done     <= 1'b1;
              state    <= DONE;
            end
            EV_STALL: begin
              status_q <= ST_STALL;
              done     <= 1'b1;
              state    <= DONE;
            end
            EV_DATA: begin
              rdata       <= dec_data;
              rdata_valid <= 1'b1;
              toggle      <= toggle ^ ep_mask;
              enc_pid     <= PID_ACK;
              state       <= SEND_ACK;
            end
            EV_DUP: begin
              enc_pid <= PID_ACK;
              state   <= SEND_ACK;
            end
            EV_NAK, EV_ERR: begin
              if (tries < RW'(MAX_TRIES)) begin
                tries   <= tries + 1'b1;
                enc_pid <= in_q ? PID_IN : PID_OUT;
                state   <= TOKEN;
              end else begin
                status_q <= (evt == EV_NAK) ? ST_NAK_LIMIT : ST_ERR_LIMIT;
                done     <= 1'b1;
                state    <= DONE;
              end
            end
            default: ;
          endcase
        end

        SEND_ACK: begin
          if (enc_ready) begin
            status_q <= ST_OK;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // NOTE: the last non-blocking write to a register in a block wins, so this
      // clear overrides any toggle flip scheduled above in the same cycle.
      if (toggle_clr) toggle <= '0;
    end
  end

endmodule

// File: tb/tb_usb_xact_engine.sv
// Directed bench for usb_xact_engine: stimulus pushes expected packets, statuses and
// read data into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_usb_xact_engine;

  localparam int DB = 8;
  localparam int DW = 8 * DB;
  localparam int MT = 8;
  localparam int TO = 16;
  localparam int NE = 4;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          start, is_in, toggle_clr;
  logic [6:0]    addr;
  logic [3:0]    endp;
  logic [DW-1:0] wdata;
  logic          busy, done, rdata_valid, enc_valid, enc_ready, re;
  logic [1:0]    status;
  logic [DW-1:0] rdata, enc_data, dec_data;
  logic [7:0]    enc_pid, dec_pid;
  logic [6:0]    enc_addr;
  logic [3:0]    enc_endp;
  logic          dec_valid, dec_corrupt;

  usb_xact_engine #(
    .DATA_BYTES(DB), .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO), .NUM_EP(NE)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .is_in(is_in), .addr(addr), .endp(endp),
    .wdata(wdata), .toggle_clr(toggle_clr), .busy(busy), .done(done), .status(status),
    .rdata(rdata), .rdata_valid(rdata_valid), .enc_valid(enc_valid), .enc_ready(enc_ready),
    .enc_pid(enc_pid), .enc_addr(enc_addr), .enc_endp(enc_endp), .enc_data(enc_data),
    .dec_valid(dec_valid), .dec_pid(dec_pid), .dec_data(dec_data),
    .dec_corrupt(dec_corrupt), .re(re)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    pid;
    logic [6:0]    addr;
    logic [3:0]    endp;
    logic [DW-1:0] data;
  } pkt_t;

  pkt_t          exp_pkt[$];
  logic [1:0]    exp_status[$];
  logic [DW-1:0] exp_rdata[$];
  bit            tog[16];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    pkt_t e;
    if (rst_b) begin
      if (enc_valid && enc_ready) begin
        if (exp_pkt.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL enc_unexpected: got pid %0h, none expected", enc_pid);
        end else begin
          e = exp_pkt.pop_front();
          check("enc_pid", DW'(enc_pid), DW'(e.pid));
          if (e.pid == PID_IN || e.pid == PID_OUT) begin
            check("enc_addr", DW'(enc_addr), DW'(e.addr));
            check("enc_endp", DW'(enc_endp), DW'(e.endp));
          end else if (e.pid == PID_DATA0 || e.pid == PID_DATA1) begin
            check("enc_data", enc_data, e.data);
          end
        end
      end
      if (done) begin
        if (exp_status.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got status %0d, no done expected", status);
        end else begin
          check("done_status", DW'(status), DW'(exp_status.pop_front()));
        end
      end
      if (rdata_valid) begin
        if (exp_rdata.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rdata_unexpected: got %0h, none expected", rdata);
        end else begin
          check("rdata", rdata, exp_rdata.pop_front());
        end
      end
    end
  end

  function automatic logic [7:0] dpid(input logic [3:0] ep);
    return (ep < NE && tog[ep]) ? PID_DATA1 : PID_DATA0;
  endfunction

  task automatic push_tok(input logic [7:0] pid, input logic [6:0] a, input logic [3:0] ep);
    pkt_t p;
    p.pid = pid; p.addr = a; p.endp = ep; p.data = '0;
    exp_pkt.push_back(p);
  endtask

  task automatic push_dat(input logic [7:0] pid, input logic [DW-1:0] d);
    pkt_t p;
    p.pid = pid; p.addr = '0; p.endp = '0; p.data = d;
    exp_pkt.push_back(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tog();
    for (int i = 0; i < 16; i++) tog[i] = 1'b0;
  endtask

  task automatic start_xact(input bit dir_in, input logic [6:0] a, input logic [3:0] ep,
                            input logic [DW-1:0] wd);
    tick();
    start = 1'b1; is_in = dir_in; addr = a; endp = ep; wdata = wd;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pkt(input logic [7:0] pid);
    int n = 0;
    while (!(enc_valid && enc_ready && enc_pid == pid)) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        expire("wait_pkt");
        return;
      end
    end
  endtask

  // Respond after the pending encoder handshake, delay cycles into the wait state.
  task automatic send_dec(input int delay, input logic [7:0] pid, input logic [DW-1:0] d,
                          input bit corrupt, input bit clr);
    @(posedge clk);
    repeat (delay) @(posedge clk);
    #1;
    dec_valid = 1'b1; dec_pid = pid; dec_data = d; dec_corrupt = corrupt; toggle_clr = clr;
    tick();
    dec_valid = 1'b0; dec_corrupt = 1'b0; toggle_clr = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        expire("wait_done");
        return;
      end
    end
  endtask

  task automatic measure_wait(output int cyc);
    cyc = 0;
    @(posedge clk);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!re) return;
      cyc++;
    end
  endtask

  task automatic run_out_ack(input logic [6:0] a, input logic [3:0] ep, input logic [DW-1:0] wd,
                             input int delay, input bit clr);
    logic [7:0] dp;
    dp = dpid(ep);
    push_tok(PID_OUT, a, ep);
    push_dat(dp, wd);
    exp_status.push_back(2'd0);
    start_xact(1'b0, a, ep, wd);
    wait_pkt(dp);
    send_dec(delay, PID_ACK, '0, 1'b0, clr);
    wait_done();
    if (clr) clear_tog();
    else if (ep < NE) tog[ep] = ~tog[ep];
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int dcount;
    rst_b = 1'b0; start = 1'b0; is_in = 1'b0; addr = '0; endp = '0; wdata = '0;
    toggle_clr = 1'b0; enc_ready = 1'b1; dec_valid = 1'b0; dec_pid = '0; dec_data = '0;
    dec_corrupt = 1'b0;
    clear_tog();
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b1;
    tick();
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    check("rst_status", DW'(status), '0);
    check("rst_rdata", rdata, '0);
    check("rst_rdata_valid", DW'(rdata_valid), '0);
    check("rst_enc_valid", DW'(enc_valid), '0);
    check("rst_re", DW'(re), '0);
    check("rst_enc_pid", DW'(enc_pid), '0);

    // OUT ep1 with encoder back-pressure, ACK 3 cycles after DATA
    enc_ready = 1'b0;
    push_tok(PID_OUT, 7'h12, 4'd1);
    push_dat(PID_DATA0, 64'hA5A5_0001_0203_0405);
    exp_status.push_back(2'd0);
    start_xact(1'b0, 7'h12, 4'd1, 64'hA5A5_0001_0203_0405);
    check("busy_after_start", DW'(busy), DW'(1));
    check("enc_valid_after_start", DW'(enc_valid), DW'(1));
    repeat (3) begin
      @(negedge clk);
      check("token_hold_valid", DW'(enc_valid), DW'(1));
      check("token_hold_pid", DW'(enc_pid), DW'(PID_OUT));
    end
    tick();
    enc_ready = 1'b1;
    wait_pkt(PID_DATA0);
    send_dec(3, PID_ACK, '0, 1'b0, 1'b0);
    wait_done();
    tog[1] = 1'b1;

    // Second OUT ep1 must use DATA1
    run_out_ack(7'h12, 4'd1, 64'h1111_2222_3333_4444, 0, 1'b0);

    // IN ep0, clean DATA0 delivered
    push_tok(PID_IN, 7'h05, 4'd0);
    push_dat(PID_ACK, '0);
    exp_rdata.push_back(64'h0123_4567_89AB_CDEF);
    exp_status.push_back(2'd0);
    start_xact(1'b1, 7'h05, 4'd0, '0);
    wait_pkt(PID_IN);
    send_dec(1, PID_DATA0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    wait_done();
    tog[0] = 1'b1;

    // Clear toggles, then IN ep0 answered with duplicate DATA1
    tick();
    toggle_clr = 1'b1;
    tick();
    toggle_clr = 1'b0;
    clear_tog();
    push_tok(PID_IN, 7'h05, 4'd0);
    push_dat(PID_ACK, '0);
    exp_status.push_back(2'd0);
    start_xact(1'b1, 7'h05, 4'd0, '0);
    wait_pkt(PID_IN);
    send_dec(0, PID_DATA1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
    wait_done();
    check("rdata_hold_after_dup", rdata, 64'h0123_4567_89AB_CDEF);
    run_out_ack(7'h05, 4'd0, 64'h0000_0000_0000_00FF, 0, 1'b0);

    // OUT ep2, NAK on every attempt
    for (int i = 0; i < MT; i++) begin
      push_tok(PID_OUT, 7'h22, 4'd2);
      push_dat(PID_DATA0, 64'h2222_0000_0000_2222);
    end
    exp_status.push_back(2'd1);
    start_xact(1'b0, 7'h22, 4'd2, 64'h2222_0000_0000_2222);
    for (int i = 0; i < MT; i++) begin
      wait_pkt(PID_DATA0);
      send_dec(1, PID_NAK, '0, 1'b0, 1'b0);
    end
    wait_done();
    check("nak_pkts_left", DW'(exp_pkt.size()), '0);
    run_out_ack(7'h22, 4'd2, 64'h5555_6666_7777_8888, 2, 1'b0);

    // IN ep3, silent device with corrupt data on attempt 3
    for (int i = 0; i < MT; i++) push_tok(PID_IN, 7'h33, 4'd3);
    exp_status.push_back(2'd2);
    start_xact(1'b1, 7'h33, 4'd3, '0);
    for (int i = 0; i < MT; i++) begin
      wait_pkt(PID_IN);
      if (i == 2) begin
        send_dec(2, PID_DATA0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b1, 1'b0);
      end else begin
        measure_wait(c);
        check("timeout_wait_cycles", DW'(c), DW'(TO));
      end
    end
    wait_done();
    check("timeout_pkts_left", DW'(exp_pkt.size()), '0);

    // OUT ep1 stalled on first attempt
    push_tok(PID_OUT, 7'h44, 4'd1);
    push_dat(PID_DATA0, 64'h4444_4444_0000_0001);
    exp_status.push_back(2'd3);
    start_xact(1'b0, 7'h44, 4'd1, 64'h4444_4444_0000_0001);
    wait_pkt(PID_DATA0);
    send_dec(0, PID_STALL, '0, 1'b0, 1'b0);
    wait_done();
    check("stall_pkts_left", DW'(exp_pkt.size()), '0);

    // toggle_clr together with ACK: toggle stays DATA0
    run_out_ack(7'h44, 4'd1, 64'h0707_0707_0707_0707, 1, 1'b1);
    run_out_ack(7'h44, 4'd1, 64'h0808_0808_0808_0808, 0, 1'b0);

    // Endpoint beyond NUM_EP never toggles
    run_out_ack(7'h50, 4'd9, 64'h0909_0909_0909_0909, 0, 1'b0);
    run_out_ack(7'h50, 4'd9, 64'h0A0A_0A0A_0A0A_0A0A, 0, 1'b0);

    // Reset while waiting for the handshake
    push_tok(PID_OUT, 7'h11, 4'd0);
    push_dat(dpid(4'd0), 64'h1010_1010_1010_1010);
    start_xact(1'b0, 7'h11, 4'd0, 64'h1010_1010_1010_1010);
    wait_pkt(dpid(4'd0));
    @(posedge clk);
    tick();
    tick();
    check("re_in_wait_hs", DW'(re), DW'(1));
    rst_b = 1'b0;
    #2;
    check("reset_abort_busy", DW'(busy), '0);
    check("reset_abort_re", DW'(re), '0);
    tick();
    rst_b = 1'b1;
    clear_tog();
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("done_after_reset", DW'(dcount), '0);
    check("busy_after_reset", DW'(busy), '0);

    check("pkts_left", DW'(exp_pkt.size()), '0);
    check("status_left", DW'(exp_status.size()), '0);
    check("rdata_left", DW'(exp_rdata.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
